// File: rtl/system_top_sdiv_48s_28ns_32_seq.sv
// Sequential radix-2 restoring divider: signed dividend / unsigned divisor -> saturated signed quotient + remainder.
// Latency: result registered on the DIVIDEND_WIDTH+2th edge counting the accept edge (50 by default); no overlap.
// Backpressure: out_valid and outputs held until out_ready; in_ready low from CALC through DONE.
//
// Ports:
//   ap_clk, ap_rst_n        clock (rising edge), synchronous active-low reset
//   in_valid/in_ready       operand handshake; dividend (signed), divisor (unsigned)
//   out_valid/out_ready     result handshake; quotient (signed, saturated), remainder (signed, sign of dividend)
//   ovf                     quotient saturated with a non-zero divisor
//   dbz                     divisor was zero

module system_top_sdiv_48s_28ns_32_seq #(
    parameter int DIVIDEND_WIDTH = 48,
    parameter int DIVISOR_WIDTH  = 28,
    parameter int QUOTIENT_WIDTH = 32
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOTIENT_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH:0]    remainder,
    output logic                      ovf,
    output logic                      dbz
);

    localparam int DW    = DIVIDEND_WIDTH;
    localparam int DS    = DIVISOR_WIDTH;
    localparam int QW    = QUOTIENT_WIDTH;
    localparam int CNT_W = $clog2(DW);

    localparam logic [QW-1:0] QMAX    = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] QMIN    = {1'b1, {(QW-1){1'b0}}};
    // Largest magnitudes representable as positive / negative quotients.
    localparam logic [DW-1:0] POS_LIM = {{(DW-QW+1){1'b0}}, {(QW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_LIM = {{(DW-QW){1'b0}}, 1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q,  cnt_d;
    // Holds |dividend| at accept; quotient bits shift in from the LSB as dividend bits leave the MSB,
    // so after DW steps it holds the quotient magnitude.
    logic [DW-1:0]    mag_q,  mag_d;
    logic [DS:0]      prem_q, prem_d;   // partial remainder, always < divisor
    logic [DS-1:0]    div_q,  div_d;
    logic             neg_q,  neg_d;
    logic             zdiv_q, zdiv_d;

    logic [QW-1:0]    quo_q,  quo_d;
    logic [DS:0]      rem_q,  rem_d;
    logic             ovf_q,  ovf_d;
    logic             dbz_q,  dbz_d;

    // One restoring step: bring down the next dividend bit and trial-subtract.
    logic [DS:0]   shifted;
    logic [DS+1:0] diff;
    logic          qbit;

    assign shifted = {prem_q[DS-1:0], mag_q[DW-1]};
    assign diff    = {1'b0, shifted} - {2'b00, div_q};
    assign qbit    = ~diff[DS+1];

    // State register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)        state_d = CALC;
            CALC:    if (cnt_q == '0)     state_d = FIX;
            FIX:                          state_d = DONE;
            DONE:    if (out_ready)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

    // Datapath next-state
    always_comb begin
        cnt_d  = cnt_q;
        mag_d  = mag_q;
        prem_d = prem_q;
        div_d  = div_q;
        neg_d  = neg_q;
        zdiv_d = zdiv_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        ovf_d  = ovf_q;
        dbz_d  = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    neg_d  = dividend[DW-1];
                    // -2^47 negates to 2^47, which is exact as an unsigned magnitude.
                    mag_d  = dividend[DW-1] ? (~dividend + DW'(1)) : dividend;
                    div_d  = divisor;
                    zdiv_d = (divisor == '0);
                    prem_d = '0;
                    cnt_d  = CNT_W'(DW-1);
                end
            end
            CALC: begin
                // A zero divisor runs the same steps; its result is overridden in FIX.
                prem_d = qbit ? diff[DS:0] : shifted;
                mag_d  = {mag_q[DW-2:0], qbit};
                cnt_d  = cnt_q - CNT_W'(1);
            end
            FIX: begin
                dbz_d = zdiv_q;
                if (zdiv_q) begin
                    quo_d = neg_q ? QMIN : QMAX;
                    rem_d = '0;
                    ovf_d = 1'b0;
                end else if (!neg_q) begin
                    if (mag_q > POS_LIM) begin
                        quo_d = QMAX;
                        ovf_d = 1'b1;
                    end else begin
                        quo_d = mag_q[QW-1:0];
                        ovf_d = 1'b0;
                    end
                    rem_d = prem_q;
                end else begin
                    // Magnitude exactly 2^(QW-1) negates to QMIN without saturating.
                    if (mag_q > NEG_LIM) begin
                        quo_d = QMIN;
                        ovf_d = 1'b1;
                    end else begin
                        quo_d = ~mag_q[QW-1:0] + QW'(1);
                        ovf_d = 1'b0;
                    end
                    rem_d = ~prem_q + (DS+1)'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cnt_q  <= '0;
            mag_q  <= '0;
            prem_q <= '0;
            div_q  <= '0;
            neg_q  <= 1'b0;
            zdiv_q <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mag_q  <= mag_d;
            prem_q <= prem_d;
            div_q  <= div_d;
            neg_q  <= neg_d;
            zdiv_q <= zdiv_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            ovf_q  <= ovf_d;
            dbz_q  <= dbz_d;
        end
    end

endmodule
